// File: rtl/nanocmos_seq_pkg.sv
// nanocmos_seq_pkg: state encoding and shared constants for frame_sequencer
// Build option: NANOCMOS_CDS_EN adds the PRST/SETTLE2/CONVERT2 states for a second conversion per pixel.
package nanocmos_seq_pkg;
    localparam logic [7:0] DEFAULT_SETTLE = 8'd2;
    localparam int FRAME_CNT_W = 16;
    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        CONVERT,
        ADVANCE
`ifdef NANOCMOS_CDS_EN
        ,
        PRST,
        SETTLE2,
        CONVERT2
`endif
    } seq_state_e;
endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: control, ADC handshake and status bundle for frame_sequencer
// master: start/abort/continuous/single-pixel config/settle_cycles/adc_done out; slave: adc_start/row_sel/col_sel/busy/frame_done/addr_err/frame_count out.
interface frame_sequencer_if #(
    parameter int PIXEL_NUM_ROW = 7,
    parameter int PIXEL_NUM_COL = 16
);
    import nanocmos_seq_pkg::*;
    logic                     start;
    logic                     abort;
    logic                     continuous;
    logic                     single_pixel_en;
    logic [7:0]               single_pixel_row_addr;
    logic [7:0]               single_pixel_col_addr;
    logic [7:0]               settle_cycles;
    logic                     adc_done;
    logic                     adc_start;
    logic [PIXEL_NUM_ROW-1:0] row_sel;
    logic [PIXEL_NUM_COL-1:0] col_sel;
    logic                     busy;
    logic                     frame_done;
    logic                     addr_err;
    logic [FRAME_CNT_W-1:0]   frame_count;
    modport master (
        output start, abort, continuous, single_pixel_en, single_pixel_row_addr,
               single_pixel_col_addr, settle_cycles, adc_done,
        input  adc_start, row_sel, col_sel, busy, frame_done, addr_err, frame_count
    );
    modport slave (
        input  start, abort, continuous, single_pixel_en, single_pixel_row_addr,
               single_pixel_col_addr, settle_cycles, adc_done,
        output adc_start, row_sel, col_sel, busy, frame_done, addr_err, frame_count
    );
endinterface

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that flags the last cycle of a max(cycles,1)-long settle window
// Ports: clk, reset (sync, active-high), clr (cancel), load (start window next cycle), cycles (length), expire (last window cycle).
module settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] cycles,
    output logic       expire
);
    logic [7:0] cnt_q, cnt_d;
    logic       run_q, run_d;
    always_comb begin
        expire = run_q && cnt_q == 8'd0;
        cnt_d  = load ? (cycles == 8'd0 ? 8'd0 : cycles - 8'd1)
                      : (run_q && cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
        run_d  = !clr && (load || (run_q && !expire));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: raster/single-pixel scan controller driving row/column selects and an ADC handshake
// Ports: clk, reset (sync, active-high), bus (frame_sequencer_if.slave). Build option: NANOCMOS_CDS_EN (two conversions per pixel).
module frame_sequencer
    import nanocmos_seq_pkg::*;
#(
    parameter int PIXEL_NUM_ROW = 7,
    parameter int PIXEL_NUM_COL = 16
) (
    input logic              clk,
    input logic              reset,
    frame_sequencer_if.slave bus
);
    localparam logic [7:0] ROW_N = 8'(PIXEL_NUM_ROW);
    localparam logic [7:0] COL_N = 8'(PIXEL_NUM_COL);
    localparam logic [7:0] ROW_LAST = 8'(PIXEL_NUM_ROW - 1);
    localparam logic [7:0] COL_LAST = 8'(PIXEL_NUM_COL - 1);
    localparam logic [PIXEL_NUM_ROW-1:0] ROW_ONE = {{(PIXEL_NUM_ROW-1){1'b0}}, 1'b1};
    localparam logic [PIXEL_NUM_COL-1:0] COL_ONE = {{(PIXEL_NUM_COL-1){1'b0}}, 1'b1};
    seq_state_e               state_q, state_d;
    logic [7:0]               row_q, row_d, col_q, col_d, settle_q, settle_d;
    logic                     cont_q, cont_d, single_q, single_d;
    logic [FRAME_CNT_W-1:0]   count_q, count_d;
    logic                     adc_start_q, adc_start_d, busy_q, busy_d;
    logic                     frame_done_q, frame_done_d, addr_err_q, addr_err_d;
    logic [PIXEL_NUM_ROW-1:0] row_sel_q, row_sel_d;
    logic [PIXEL_NUM_COL-1:0] col_sel_q, col_sel_d;
    logic                     last_px, oob, launch, finish_px, timer_load, expire;
    settle_timer u_settle (
        .clk    (clk),
        .reset  (reset),
        .clr    (bus.abort),
        .load   (timer_load),
        .cycles (settle_q),
        .expire (expire)
    );
    always_comb begin
        last_px    = single_q || (row_q == ROW_LAST && col_q == COL_LAST);
        oob        = bus.single_pixel_row_addr >= ROW_N || bus.single_pixel_col_addr >= COL_N;
`ifdef NANOCMOS_CDS_EN
        timer_load = state_q == SELECT || state_q == PRST;
`else
        timer_load = state_q == SELECT;
`endif
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        settle_d     = settle_q;
        cont_d       = cont_q;
        single_d     = single_q;
        count_d      = count_q;
        frame_done_d = 1'b0;
        addr_err_d   = 1'b0;
        launch       = 1'b0;
        finish_px    = 1'b0;
        case (state_q)
            IDLE:     launch = bus.start;
            SELECT:   state_d = SETTLE;
            SETTLE:   state_d = expire ? CONVERT : SETTLE;
`ifdef NANOCMOS_CDS_EN
            CONVERT:  state_d = bus.adc_done ? PRST : CONVERT;
            PRST:     state_d = SETTLE2;
            SETTLE2:  state_d = expire ? CONVERT2 : SETTLE2;
            CONVERT2: finish_px = bus.adc_done;
`else
            CONVERT:  finish_px = bus.adc_done;
`endif
            ADVANCE: begin
                // Column is the inner loop; on the last pixel the step is overridden by a relaunch or masked in IDLE.
                state_d = last_px ? IDLE : SELECT;
                launch  = last_px && cont_q && bus.continuous;
                col_d   = col_q == COL_LAST ? 8'd0 : col_q + 8'd1;
                row_d   = col_q == COL_LAST ? row_q + 8'd1 : row_q;
            end
            default:  state_d = IDLE;
        endcase
        if (finish_px) begin
            state_d      = ADVANCE;
            frame_done_d = last_px;
            count_d      = count_q + {{(FRAME_CNT_W-1){1'b0}}, last_px};
        end
        // Configuration is captured at every frame launch so mid-frame input changes are ignored.
        if (launch) begin
            cont_d     = bus.continuous;
            single_d   = bus.single_pixel_en;
            settle_d   = bus.settle_cycles;
            row_d      = bus.single_pixel_en ? bus.single_pixel_row_addr : 8'd0;
            col_d      = bus.single_pixel_en ? bus.single_pixel_col_addr : 8'd0;
            addr_err_d = bus.single_pixel_en && oob;
            state_d    = addr_err_d ? IDLE : SELECT;
        end
        if (bus.abort) begin
            state_d      = IDLE;
            frame_done_d = 1'b0;
            addr_err_d   = 1'b0;
            count_d      = count_q;
        end
        busy_d      = state_d != IDLE;
`ifdef NANOCMOS_CDS_EN
        adc_start_d = state_d == CONVERT || state_d == CONVERT2;
`else
        adc_start_d = state_d == CONVERT;
`endif
        row_sel_d   = busy_d ? ROW_ONE << row_d : '0;
        col_sel_d   = busy_d ? COL_ONE << col_d : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= 8'd0;
            col_q        <= 8'd0;
            settle_q     <= DEFAULT_SETTLE;
            cont_q       <= 1'b0;
            single_q     <= 1'b0;
            count_q      <= '0;
            adc_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
            row_sel_q    <= '0;
            col_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            settle_q     <= settle_d;
            cont_q       <= cont_d;
            single_q     <= single_d;
            count_q      <= count_d;
            adc_start_q  <= adc_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            addr_err_q   <= addr_err_d;
            row_sel_q    <= row_sel_d;
            col_sel_q    <= col_sel_d;
        end
    end
    assign bus.adc_start   = adc_start_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.frame_count = count_q;
    assign bus.row_sel     = row_sel_q;
    assign bus.col_sel     = col_sel_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboarded bench for frame_sequencer (honours NANOCMOS_CDS_EN)
module tb_frame_sequencer;
    localparam int ROWS = 7;
    localparam int COLS = 16;
`ifdef NANOCMOS_CDS_EN
    localparam int CPP = 2;
`else
    localparam int CPP = 1;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    frame_sequencer_if #(.PIXEL_NUM_ROW(ROWS), .PIXEL_NUM_COL(COLS)) bus ();
    frame_sequencer #(.PIXEL_NUM_ROW(ROWS), .PIXEL_NUM_COL(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    int          n_cmp = 0;
    int          n_err = 0;
    int          rises = 0;
    int          fds = 0;
    int          aes = 0;
    logic [22:0] exp_q[$];
    logic [15:0] exp_fc = 16'd0;
    bit          adc_auto = 1'b1;
    bit          man_done = 1'b0;

    function automatic logic [22:0] px(int r, int c);
        logic [6:0]  ro;
        logic [15:0] co;
        ro = 7'd1 << r;
        co = 16'd1 << c;
        return {ro, co};
    endfunction

    task automatic push_px(int r, int c);
        repeat (CPP) exp_q.push_back(px(r, c));
    endtask

    // ADC model: adc_done for one cycle, three cycles after each adc_start rise
    initial begin : adc_model
        logic prev;
        int   cnt;
        logic fire;
        prev = 1'b0;
        cnt = 0;
        bus.adc_done = 1'b0;
        forever begin
            @(negedge clk);
            fire = 1'b0;
            if (cnt > 0) begin
                cnt--;
                fire = (cnt == 0);
            end
            if (adc_auto && bus.adc_start && !prev) cnt = 2;
            prev = bus.adc_start;
            bus.adc_done = fire || man_done;
        end
    end

    // Scoreboard: every adc_start rise must match the next expected pixel select
    initial begin : monitor
        logic        prev;
        logic [22:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.frame_done) fds++;
            if (bus.addr_err) aes++;
            if (bus.adc_start && !prev) begin
                rises++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: adc_start rise at row_sel=%h col_sel=%h, none expected", bus.row_sel, bus.col_sel);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.row_sel, bus.col_sel} !== e) begin
                        n_err++;
                        $display("FAIL sb_pixel: row_sel=%h col_sel=%h, expected row_sel=%h col_sel=%h", bus.row_sel, bus.col_sel, e[22:16], e[15:0]);
                    end
                end
            end
            prev = bus.adc_start;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic idle_wait(string name, int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.busy && t < budget);
        n_cmp++;
        if (bus.busy) begin
            n_err++;
            $display("FAIL %s_timeout: busy=1 after %0d cycles, expected 0", name, t);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.continuous = 1'b0;
        bus.single_pixel_en = 1'b0;
        bus.single_pixel_row_addr = 8'd0;
        bus.single_pixel_col_addr = 8'd0;
        bus.settle_cycles = 8'd2;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.adc_start, bus.frame_done, bus.addr_err} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy/adc_start/frame_done/addr_err=%b, expected 0000", {bus.busy, bus.adc_start, bus.frame_done, bus.addr_err});
        end
        n_cmp++;
        if (bus.row_sel !== 7'd0) begin
            n_err++;
            $display("FAIL reset_row_sel: %h, expected 00", bus.row_sel);
        end
        n_cmp++;
        if (bus.col_sel !== 16'd0) begin
            n_err++;
            $display("FAIL reset_col_sel: %h, expected 0000", bus.col_sel);
        end
        n_cmp++;
        if (bus.frame_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_frame_count: %0d, expected 0", bus.frame_count);
        end
    endtask

    // Start-to-first-conversion latency: SELECT (1) + SETTLE max(n,1), so adc_start seen on negedge max(n,1)+2
    task automatic test_latency();
        int sv[3] = '{0, 1, 5};
        int k;
        int exp_k;
        bus.single_pixel_en = 1'b1;
        bus.single_pixel_row_addr = 8'd0;
        bus.single_pixel_col_addr = 8'd0;
        for (int i = 0; i < 3; i++) begin
            bus.settle_cycles = 8'(sv[i]);
            exp_k = (sv[i] == 0 ? 1 : sv[i]) + 2;
            push_px(0, 0);
            pulse_start();
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.adc_start && k < 40);
            n_cmp++;
            if (k !== exp_k) begin
                n_err++;
                $display("FAIL latency_settle%0d: adc_start after %0d cycles, expected %0d", sv[i], k, exp_k);
            end
            idle_wait("latency", 100);
            exp_fc++;
        end
        n_cmp++;
        if (bus.frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL latency_frame_count: %0d, expected %0d", bus.frame_count, exp_fc);
        end
    endtask

    task automatic test_full_frame();
        int r0;
        int f0;
        r0 = rises;
        f0 = fds;
        bus.single_pixel_en = 1'b0;
        bus.continuous = 1'b0;
        bus.settle_cycles = 8'd2;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push_px(r, c);
        pulse_start();
        idle_wait("full_frame", 4000);
        exp_fc++;
        n_cmp++;
        if (rises - r0 !== ROWS * COLS * CPP) begin
            n_err++;
            $display("FAIL full_rises: %0d, expected %0d", rises - r0, ROWS * COLS * CPP);
        end
        n_cmp++;
        if (fds - f0 !== 1) begin
            n_err++;
            $display("FAIL full_frame_done: %0d pulses, expected 1", fds - f0);
        end
        n_cmp++;
        if (bus.frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL full_frame_count: %0d, expected %0d", bus.frame_count, exp_fc);
        end
        n_cmp++;
        if ({bus.row_sel, bus.col_sel} !== 23'd0) begin
            n_err++;
            $display("FAIL full_idle_sel: row_sel=%h col_sel=%h, expected 0", bus.row_sel, bus.col_sel);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL full_pending: %0d conversions missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_continuous();
        int f0;
        int t;
        int gaps;
        f0 = fds;
        t = 0;
        gaps = 0;
        bus.single_pixel_en = 1'b0;
        bus.continuous = 1'b1;
        bus.settle_cycles = 8'd1;
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) push_px(r, c);
        pulse_start();
        while (fds - f0 < 3 && t < 6000) begin
            @(negedge clk);
            #1;
            t++;
            if (!bus.busy) gaps++;
            if (fds - f0 == 2 && bus.adc_start) bus.continuous = 1'b0;
        end
        idle_wait("continuous", 20);
        exp_fc += 16'd3;
        n_cmp++;
        if (fds - f0 !== 3) begin
            n_err++;
            $display("FAIL cont_frame_done: %0d pulses, expected 3", fds - f0);
        end
        n_cmp++;
        if (gaps !== 0) begin
            n_err++;
            $display("FAIL cont_gap: %0d idle cycles between frames, expected 0", gaps);
        end
        n_cmp++;
        if (bus.frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL cont_frame_count: %0d, expected %0d", bus.frame_count, exp_fc);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL cont_pending: %0d conversions missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_single_pixel();
        int r0;
        int f0;
        int a0;
        int bad[2][2] = '{'{7, 0}, '{0, 16}};
        r0 = rises;
        f0 = fds;
        bus.continuous = 1'b0;
        bus.single_pixel_en = 1'b1;
        bus.single_pixel_row_addr = 8'd3;
        bus.single_pixel_col_addr = 8'd9;
        bus.settle_cycles = 8'd2;
        push_px(3, 9);
        pulse_start();
        bus.single_pixel_row_addr = 8'd0;
        bus.single_pixel_col_addr = 8'd0;
        idle_wait("single", 100);
        exp_fc++;
        n_cmp++;
        if (rises - r0 !== CPP) begin
            n_err++;
            $display("FAIL single_rises: %0d, expected %0d", rises - r0, CPP);
        end
        n_cmp++;
        if (fds - f0 !== 1) begin
            n_err++;
            $display("FAIL single_frame_done: %0d pulses, expected 1", fds - f0);
        end
        n_cmp++;
        if (bus.frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL single_frame_count: %0d, expected %0d", bus.frame_count, exp_fc);
        end
        for (int i = 0; i < 2; i++) begin
            r0 = rises;
            a0 = aes;
            bus.single_pixel_row_addr = 8'(bad[i][0]);
            bus.single_pixel_col_addr = 8'(bad[i][1]);
            pulse_start();
            idle_wait("addr_err", 20);
            n_cmp++;
            if (aes - a0 !== 1) begin
                n_err++;
                $display("FAIL addr_err_pulse(%0d,%0d): %0d pulses, expected 1", bad[i][0], bad[i][1], aes - a0);
            end
            n_cmp++;
            if (rises - r0 !== 0 || bus.frame_count !== exp_fc) begin
                n_err++;
                $display("FAIL addr_err_effect(%0d,%0d): rises=%0d frame_count=%0d, expected 0 and %0d", bad[i][0], bad[i][1], rises - r0, bus.frame_count, exp_fc);
            end
        end
    endtask

    task automatic test_abort();
        int r0;
        int f0;
        int k;
        r0 = rises;
        f0 = fds;
        adc_auto = 1'b0;
        bus.single_pixel_en = 1'b1;
        bus.single_pixel_row_addr = 8'd4;
        bus.single_pixel_col_addr = 8'd6;
        bus.settle_cycles = 8'd2;
        exp_q.push_back(px(4, 6));
        pulse_start();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.adc_start && k < 30);
        n_cmp++;
        if (!bus.adc_start) begin
            n_err++;
            $display("FAIL abort_reach_convert: adc_start=0 after %0d cycles, expected 1", k);
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.adc_start, bus.row_sel, bus.col_sel} !== 25'd0) begin
            n_err++;
            $display("FAIL abort_outputs: busy=%b adc_start=%b row_sel=%h col_sel=%h, expected all 0", bus.busy, bus.adc_start, bus.row_sel, bus.col_sel);
        end
        n_cmp++;
        if (bus.frame_count !== exp_fc) begin
            n_err++;
            $display("FAIL abort_frame_count: %0d, expected %0d", bus.frame_count, exp_fc);
        end
        @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || fds - f0 !== 0 || rises - r0 !== 1) begin
            n_err++;
            $display("FAIL abort_late_done: busy=%b frame_done_pulses=%0d rises=%0d, expected 0, 0, 1", bus.busy, fds - f0, rises - r0);
        end
        adc_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        int r0;
        int t;
        r0 = rises;
        t = 0;
        bus.single_pixel_en = 1'b0;
        bus.continuous = 1'b0;
        bus.settle_cycles = 8'd4;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < COLS; c++)
                if (r < 2 || c < 5) push_px(r, c);
        pulse_start();
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!(rises - r0 == 37 * CPP && bus.row_sel == 7'h04 && bus.col_sel == 16'h0020) && t < 3000);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.adc_start !== 1'b0 || bus.col_sel !== 16'h0020) begin
            n_err++;
            $display("FAIL rmid_settle: busy=%b adc_start=%b col_sel=%h, expected 1, 0, 0020", bus.busy, bus.adc_start, bus.col_sel);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_fc = 16'd0;
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.adc_start, bus.frame_done, bus.addr_err, bus.row_sel, bus.col_sel} !== 27'd0) begin
            n_err++;
            $display("FAIL rmid_outputs: busy=%b adc_start=%b row_sel=%h col_sel=%h, expected all 0", bus.busy, bus.adc_start, bus.row_sel, bus.col_sel);
        end
        n_cmp++;
        if (bus.frame_count !== 16'd0 || exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL rmid_state: frame_count=%0d pending=%0d, expected 0 and 0", bus.frame_count, exp_q.size());
        end
        bus.settle_cycles = 8'd1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push_px(r, c);
        pulse_start();
        idle_wait("rmid_rescan", 4000);
        exp_fc++;
        n_cmp++;
        if (bus.frame_count !== exp_fc || exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL rmid_rescan: frame_count=%0d pending=%0d, expected %0d and 0", bus.frame_count, exp_q.size(), exp_fc);
        end
    endtask

`ifdef NANOCMOS_CDS_EN
    task automatic test_cds();
        int k;
        int lo;
        bus.single_pixel_en = 1'b1;
        bus.single_pixel_row_addr = 8'd1;
        bus.single_pixel_col_addr = 8'd1;
        bus.settle_cycles = 8'd3;
        push_px(1, 1);
        pulse_start();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.adc_start && k < 30);
        do begin
            @(negedge clk);
            k++;
        end while (bus.adc_start && k < 60);
        lo = 0;
        while (!bus.adc_start && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        n_cmp++;
        if (lo !== 4) begin
            n_err++;
            $display("FAIL cds_gap: adc_start low %0d cycles between conversions, expected 4", lo);
        end
        idle_wait("cds", 100);
        exp_fc++;
        n_cmp++;
        if (bus.frame_count !== exp_fc || exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL cds_done: frame_count=%0d pending=%0d, expected %0d and 0", bus.frame_count, exp_q.size(), exp_fc);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.continuous = 1'b0;
        bus.single_pixel_en = 1'b0;
        bus.single_pixel_row_addr = 8'd0;
        bus.single_pixel_col_addr = 8'd0;
        bus.settle_cycles = 8'd2;
        test_reset();
        test_latency();
        test_full_frame();
        test_continuous();
        test_single_pixel();
        test_abort();
        test_reset_mid();
`ifdef NANOCMOS_CDS_EN
        test_cds();
`endif
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL final_pending: %0d conversions missing, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter PIXEL_NUM_ROW, default 7, number of pixel rows.
REQ-002 Parameter PIXEL_NUM_COL, default 16, number of pixel columns.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 abort  input  1  terminates any scan; priority over every input except reset.
REQ-007 continuous  input  1  1 = restart at the next frame automatically.
REQ-008 single_pixel_en  input  1  1 = scan only the addressed pixel.
REQ-009 single_pixel_row_addr  input  8  row address for single-pixel mode.
REQ-010 single_pixel_col_addr  input  8  column address for single-pixel mode.
REQ-011 settle_cycles  input  8  settle time before conversion, in clk cycles.
REQ-012 adc_done  input  1  ADC conversion complete.
REQ-013 adc_start  output  1  ADC conversion request.
REQ-014 row_sel  output  PIXEL_NUM_ROW  one-hot row select.
REQ-015 col_sel  output  PIXEL_NUM_COL  one-hot column select.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 frame_done  output  1  one-cycle pulse at the end of each frame.
REQ-018 addr_err  output  1  one-cycle pulse when a single-pixel address is out of range.
REQ-019 frame_count  output  16  number of completed frames.

Function
REQ-020 States SHALL be IDLE, SELECT, SETTLE, CONVERT, ADVANCE, plus PRST, SETTLE2 and CONVERT2 when CDS is compiled in.
REQ-021 IDLE -> SELECT SHALL occur on the edge at which start=1; start in any other state SHALL be ignored.
REQ-022 At that edge continuous, single_pixel_en, both addresses and settle_cycles SHALL be latched; changes during the frame SHALL have no effect.
REQ-023 SELECT SHALL last 1 cycle with the current row_sel/col_sel bits driven; they SHALL stay driven until ADVANCE ends.
REQ-024 SETTLE SHALL last max(settle_cycles,1) cycles.
REQ-025 In CONVERT, adc_start SHALL be 1 from the first CONVERT cycle until the cycle in which adc_done=1 is sampled, and SHALL be 0 the following cycle.
REQ-026 adc_done outside CONVERT/CONVERT2 SHALL be ignored.
REQ-027 ADVANCE SHALL last 1 cycle and step the column; column is the inner loop (0..PIXEL_NUM_COL-1), row the outer loop.
REQ-028 After pixel (PIXEL_NUM_ROW-1, PIXEL_NUM_COL-1), ADVANCE SHALL pulse frame_done and increment frame_count, which wraps from 0xFFFF to 0.
REQ-029 At frame end: continuous=1 -> SELECT at (0,0) next cycle; continuous=0 -> IDLE.
REQ-030 Single-pixel mode: one pixel per frame; frame_done and frame_count behave as in a full frame.
REQ-031 Single-pixel address with row >= PIXEL_NUM_ROW or col >= PIXEL_NUM_COL: pulse addr_err, no conversion, return to IDLE, frame_count unchanged.
REQ-032 abort=1 in any state: IDLE next cycle; adc_start, row_sel and col_sel cleared; frame_done not pulsed; frame_count unchanged.
REQ-033 In IDLE, row_sel and col_sel SHALL be all-zero; at most one bit of each SHALL ever be set.

Reset
REQ-034 reset=1 SHALL force IDLE, all outputs to 0 and frame_count to 0 on the next edge, including mid-conversion.

Configuration
REQ-035 Macro NANOCMOS_CDS_EN defined: each pixel runs CONVERT -> PRST (1 cycle; row/col held) -> SETTLE2 (max(settle_cycles,1) cycles) -> CONVERT2 (same handshake as CONVERT) -> ADVANCE, giving two conversions per pixel.
REQ-036 NANOCMOS_CDS_EN undefined: CONVERT -> ADVANCE, one conversion per pixel; PRST, SETTLE2 and CONVERT2 are absent.

Structure
REQ-037 Package nanocmos_seq_pkg SHALL hold the state enum typedef and the default settle and frame-counter-width constants.
REQ-038 Sub-module settle_timer (load, count-down, expire pulse) SHALL implement SETTLE and SETTLE2.

Verification
REQ-039 settle_cycles=2, adc_done returned 3 cycles after each adc_start rise, full frame -> exactly 112 adc_start rises, columns stepping 0..15 per row, one frame_done, frame_count=1, IDLE.
REQ-040 continuous=1 for 3 frames, then deassert -> frame_count=3, no idle gap between frames, IDLE after the third frame_done.
REQ-041 single_pixel_en=1, row=3, col=9 -> single conversion with row_sel=0x08, col_sel=0x0200; row=7 -> addr_err pulse, no adc_start.
REQ-042 abort during CONVERT with adc_start high -> IDLE next cycle, all outputs 0, frame_count unchanged; a later adc_done is ignored.
REQ-043 reset during SETTLE of pixel (2,5) -> all outputs 0 next cycle; a new start scans from (0,0).
REQ-044 NANOCMOS_CDS_EN defined, single pixel -> two adc_start handshakes separated by PRST plus settle_cycles cycles.
